// File: rtl/alu_sliced_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_sliced_seq
// Brief    : Multi-cycle ALU processing one SLICE-bit chunk per clock, LSB
//            first, with the carry registered between slices. Optional macro
//            ALU_LOGIC_FASTPATH_EN lets AND/OR finish in a single cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sliced_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int NSLICES = ((WIDTH / SLICE) < 1) ? 1 : (WIDTH / SLICE);
    localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NSLICES - 1);
    localparam logic [1:0]       C_OP_SLT   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;      // already conditionally inverted (B')
    logic [1:0]       r_op;
    logic [IDX_W-1:0] r_idx;
    logic             r_cy;

    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE-1:0] w_logic_sl;
    logic [SLICE-1:0] w_slice_res;
    logic [SLICE:0]   w_sum;
    logic             w_ovf;
    logic             w_less;
    logic             w_last;
    logic [WIDTH-1:0] w_next_result;

    // Select the active slice with constant-index muxing.
    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int i = 0; i < NSLICES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_sl = r_a[i*SLICE +: SLICE];
                w_b_sl = r_b[i*SLICE +: SLICE];
            end
        end
    end

    always_comb begin
        w_sum       = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_cy};
        // Signed overflow: operands agree in sign but the sum does not.
        w_ovf       = (w_a_sl[SLICE-1] == w_b_sl[SLICE-1]) &&
                      (w_sum[SLICE-1] != w_a_sl[SLICE-1]);
        w_less      = w_sum[SLICE-1] ^ w_ovf;
        w_logic_sl  = r_op[0] ? (w_a_sl | w_b_sl) : (w_a_sl & w_b_sl);
        w_slice_res = r_op[1] ? w_sum[SLICE-1:0] : w_logic_sl;
        w_last      = (r_idx == C_LAST_IDX);
    end

    always_comb begin
        w_next_result = result;
        for (int i = 0; i < NSLICES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_next_result[i*SLICE +: SLICE] = w_slice_res;
            end
        end
        if (w_last && (r_op == C_OP_SLT)) begin
            w_next_result = WIDTH'(w_less);
        end
    end

`ifdef ALU_LOGIC_FASTPATH_EN
    logic [WIDTH-1:0] w_fast_b;
    logic [WIDTH-1:0] w_fast_res;

    always_comb begin
        w_fast_b   = op[2] ? ~b : b;
        w_fast_res = op[0] ? (a | w_fast_b) : (a & w_fast_b);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_idx     <= '0;
            r_cy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a      <= a;
                        r_b      <= op[2] ? ~b : b;
                        r_op     <= op[1:0];
                        r_cy     <= op[2];
                        r_idx    <= '0;
                        in_ready <= 1'b0;
`ifdef ALU_LOGIC_FASTPATH_EN
                        if (!op[1]) begin
                            result    <= w_fast_res;
                            zero      <= (w_fast_res == '0);
                            carry     <= 1'b0;
                            overflow  <= 1'b0;
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_state   <= S_RUN;
                        end
`else
                        r_state  <= S_RUN;
`endif
                    end
                end

                S_RUN: begin
                    result <= w_next_result;
                    r_cy   <= w_sum[SLICE];
                    r_idx  <= r_idx + 1'b1;
                    if (w_last) begin
                        zero      <= (w_next_result == '0);
                        carry     <= r_op[1] & w_sum[SLICE];
                        overflow  <= r_op[1] & w_ovf;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end

                S_DONE: begin
                    // Result and flags stay frozen until the consumer takes them.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
